// File: rtl/blue_motion_ctrl.sv
// blue_motion_ctrl: per-frame position and animation integrator for the blue sprite.
// Optional BLUE_DOUBLE_JUMP_EN grants one mid-air jump per landing.
module blue_motion_ctrl #(
  parameter logic [9:0] X_INIT   = 10'd32,
  parameter logic [8:0] Y_INIT   = 9'd400,
  parameter logic [9:0] X_MAX    = 10'd623,
  parameter logic [8:0] Y_MAX    = 9'd463,
  parameter logic [2:0] SPEED    = 3'd2,
  parameter logic [4:0] JUMP_V   = 5'd8,
  parameter logic [4:0] MAX_FALL = 5'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] wsad_down,
  input  logic [1:0] collision_state,
  output logic [9:0] x_blue,
  output logic [8:0] y_blue,
  output logic [2:0] blue_state,
  output logic       on_ground
);

  typedef enum logic [1:0] {GROUND, RISE, FALL} vstate_t;

  localparam logic [1:0] C_FLOOR = 2'b01;
  localparam logic [1:0] C_CEIL  = 2'b10;
  localparam logic [1:0] C_WALL  = 2'b11;

  localparam logic signed [10:0] SPEED_S    = signed'(11'(SPEED));
  localparam logic signed [10:0] X_MAX_S    = signed'(11'(X_MAX));
  localparam logic signed [10:0] Y_MAX_S    = signed'(11'(Y_MAX));
  localparam logic signed [5:0]  JUMP_S     = -signed'(6'(JUMP_V));
  localparam logic signed [5:0]  MAX_FALL_S = signed'(6'(MAX_FALL));

  vstate_t            st_q, st_d;
  logic signed [5:0]  vy_q, vy_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic [2:0]         blue_state_q;
  logic               on_ground_q;

  logic               key_w, key_a, key_d;
  logic               hit_floor, hit_ceil;
  logic signed [10:0] x_sum, y_sum;
  logic               y_lo, y_hi;
  logic [8:0]         y_clamp;
  logic signed [5:0]  vy_inc, vy_fall;

`ifdef BLUE_DOUBLE_JUMP_EN
  logic credit_q, credit_d;
  logic w_prev_q;
`endif

  assign key_w     = wsad_down[3];
  assign key_a     = wsad_down[1];
  assign key_d     = wsad_down[0];
  assign hit_floor = (collision_state == C_FLOOR);
  assign hit_ceil  = (collision_state == C_CEIL);

  always_comb begin
    x_sum = signed'(11'(x_q));
    if (collision_state != C_WALL && (key_a ^ key_d))
      x_sum = key_a ? x_sum - SPEED_S : x_sum + SPEED_S;
    if (x_sum < 0)            x_d = '0;
    else if (x_sum > X_MAX_S) x_d = X_MAX;
    else                      x_d = x_sum[9:0];
  end

  assign y_sum   = signed'(11'(y_q)) + 11'(vy_q);
  assign y_lo    = (y_sum < 0);
  assign y_hi    = (y_sum > Y_MAX_S);
  assign y_clamp = y_lo ? 9'd0 : (y_hi ? Y_MAX : y_sum[8:0]);
  assign vy_inc  = vy_q + 6'sd1;
  assign vy_fall = (vy_inc > MAX_FALL_S) ? MAX_FALL_S : vy_inc;

  always_comb begin
    st_d = st_q;
    vy_d = vy_q;
    y_d  = y_q;
`ifdef BLUE_DOUBLE_JUMP_EN
    credit_d = credit_q;
`endif
    case (st_q)
      GROUND: begin
        if (key_w && !hit_ceil) begin
          vy_d = JUMP_S;
          st_d = RISE;
        end else if (!hit_floor) begin
          vy_d = 6'sd1;
          st_d = FALL;
        end else begin
          vy_d = '0;
        end
      end
      RISE: begin
        if (hit_ceil) begin
          vy_d = '0;
          st_d = FALL;
        end else begin
          y_d = y_clamp;
          // Clamping at the top of the screen acts as an implicit ceiling.
          if (y_lo) begin
            vy_d = '0;
            st_d = FALL;
          end else if (y_hi) begin
            vy_d = '0;
            st_d = GROUND;
          end else begin
            vy_d = vy_inc;
            if (!vy_inc[5]) st_d = FALL;
          end
        end
      end
      FALL: begin
        if (hit_floor) begin
          vy_d = '0;
          st_d = GROUND;
        end else begin
          y_d = y_clamp;
          if (y_hi) begin
            vy_d = '0;
            st_d = GROUND;
          end else begin
            vy_d = vy_fall;
          end
        end
      end
      default: begin
        vy_d = '0;
        st_d = FALL;
      end
    endcase
`ifdef BLUE_DOUBLE_JUMP_EN
    if (st_q != GROUND && key_w && !w_prev_q && credit_q) begin
      vy_d     = JUMP_S;
      st_d     = RISE;
      y_d      = y_q;
      credit_d = 1'b0;
    end
    if (st_q != GROUND && st_d == GROUND) credit_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= FALL;
      vy_q         <= '0;
      x_q          <= X_INIT;
      y_q          <= Y_INIT;
      blue_state_q <= 3'd4;
      on_ground_q  <= 1'b0;
`ifdef BLUE_DOUBLE_JUMP_EN
      credit_q     <= 1'b0;
      w_prev_q     <= 1'b0;
`endif
    end else if (tick) begin
      st_q        <= st_d;
      vy_q        <= vy_d;
      x_q         <= x_d;
      y_q         <= y_d;
      on_ground_q <= (st_d == GROUND);
      case (st_d)
        RISE:    blue_state_q <= 3'd3;
        FALL:    blue_state_q <= 3'd4;
        default: blue_state_q <= (key_a && !key_d) ? 3'd1 :
                                 (key_d && !key_a) ? 3'd2 : 3'd0;
      endcase
`ifdef BLUE_DOUBLE_JUMP_EN
      credit_q    <= credit_d;
      w_prev_q    <= key_w;
`endif
    end
  end

  assign x_blue     = x_q;
  assign y_blue     = y_q;
  assign blue_state = blue_state_q;
  assign on_ground  = on_ground_q;

endmodule

// File: tb/tb_blue_motion_ctrl.sv
// Directed bench for blue_motion_ctrl; X_INIT overridden to an odd value so the x=1 -> 0 clamp is reachable.
module tb_blue_motion_ctrl;

  localparam logic [9:0] XI = 10'd99;
  localparam logic [3:0] K_0  = 4'b0000;
  localparam logic [3:0] K_A  = 4'b0010;
  localparam logic [3:0] K_D  = 4'b0001;
  localparam logic [3:0] K_AD = 4'b0011;
  localparam logic [3:0] K_W  = 4'b1000;
  localparam logic [1:0] C_FREE  = 2'b00;
  localparam logic [1:0] C_FLOOR = 2'b01;
  localparam logic [1:0] C_CEIL  = 2'b10;
  localparam logic [1:0] C_WALL  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] wsad_down;
  logic [1:0] collision_state;
  logic [9:0] x_blue;
  logic [8:0] y_blue;
  logic [2:0] blue_state;
  logic       on_ground;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blue_motion_ctrl #(.X_INIT(XI)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .wsad_down(wsad_down),
    .collision_state(collision_state),
    .x_blue(x_blue),
    .y_blue(y_blue),
    .blue_state(blue_state),
    .on_ground(on_ground)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int ey, input int ebs, input int eog);
    check({tag, ".x"},  32'(x_blue),     32'(ex));
    check({tag, ".y"},  32'(y_blue),     32'(ey));
    check({tag, ".bs"}, 32'(blue_state), 32'(ebs));
    check({tag, ".og"}, 32'(on_ground),  32'(eog));
  endtask

  task automatic step(input logic [3:0] keys, input logic [1:0] coll);
    @(negedge clk);
    wsad_down       = keys;
    collision_state = coll;
    tick            = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ey;
    int  v;
    bit  landed;

    reset = 1'b1; tick = 1'b0; wsad_down = K_0; collision_state = C_FLOOR;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 99, 400, 4, 0);
    @(negedge clk);
    reset = 1'b0;

    step(K_0, C_FLOOR);
    check_all("settle", 99, 400, 0, 1);

    @(negedge clk);
    wsad_down = K_D;
    repeat (3) @(posedge clk);
    #1;
    check("no_tick_hold.x", 32'(x_blue), 32'd99);

    repeat (49) step(K_A, C_FLOOR);
    check_all("run_left", 1, 400, 1, 1);
    step(K_A, C_FLOOR);
    check("clamp_x0", 32'(x_blue), 32'd0);
    step(K_A, C_FLOOR);
    check("stay_x0", 32'(x_blue), 32'd0);

    repeat (50) step(K_D, C_FLOOR);
    check("run_right_100", 32'(x_blue), 32'd100);
    repeat (5) step(K_D, C_FLOOR);
    check_all("run_right_110", 110, 400, 2, 1);
    step(K_AD, C_FLOOR);
    check_all("both_keys", 110, 400, 0, 1);

    step(K_W, C_FLOOR);
    check_all("jump_start", 110, 400, 3, 0);
    ey = 400;
    for (int k = 8; k >= 1; k--) begin
      step(K_0, C_FREE);
      ey -= k;
      check("rise.y", 32'(y_blue), 32'(ey));
      check("rise.bs", 32'(blue_state), (k > 1) ? 32'd3 : 32'd4);
    end
    step(K_0, C_FREE);
    check_all("apex", 110, 364, 4, 0);
    step(K_0, C_FLOOR);
    check_all("land", 110, 364, 0, 1);
    step(K_0, C_FREE);
    check_all("walk_off", 110, 364, 4, 0);
    step(K_0, C_FREE);
    check("fall_vy1.y", 32'(y_blue), 32'd365);
    step(K_0, C_FLOOR);
    check_all("land2", 110, 365, 0, 1);

    step(K_W, C_FLOOR);
    check_all("jump2", 110, 365, 3, 0);
    step(K_0, C_FREE);
    check("jump2_rise.y", 32'(y_blue), 32'd357);
    step(K_0, C_CEIL);
    check_all("ceiling", 110, 357, 4, 0);
    step(K_0, C_FREE);
    check("after_ceil.y", 32'(y_blue), 32'd357);
    step(K_D, C_WALL);
    check_all("wall", 110, 358, 4, 0);
    step(K_D, C_FREE);
    check_all("air_move", 112, 360, 4, 0);

    ey = 360; v = 3; landed = 1'b0;
    for (int n = 0; n < 40 && !landed; n++) begin
      step(K_0, C_FREE);
      ey += v;
      if (ey > 463) begin
        ey = 463;
        landed = 1'b1;
      end
      v = (v < 6) ? v + 1 : 6;
      check("fall.y", 32'(y_blue), 32'(ey));
    end
    check("fall_landed", 32'(landed), 32'd1);
    check_all("floor_clamp", 112, 463, 0, 1);

    step(K_W, C_FLOOR);
    step(K_0, C_FREE);
    check_all("mid_jump", 112, 455, 3, 0);
    @(negedge clk);
    reset = 1'b1; tick = 1'b1; wsad_down = K_D; collision_state = C_FREE;
    @(posedge clk);
    #1;
    check_all("reset_over_tick", 99, 400, 4, 0);
    @(negedge clk);
    reset = 1'b0; tick = 1'b0;

`ifdef BLUE_DOUBLE_JUMP_EN
    step(K_0, C_FLOOR);
    step(K_W, C_FLOOR);
    check_all("dj_first", 99, 400, 3, 0);
    step(K_W, C_FREE);
    check("dj_hold.y", 32'(y_blue), 32'd392);
    step(K_0, C_FREE);
    check("dj_release.y", 32'(y_blue), 32'd385);
    step(K_W, C_FREE);
    check_all("dj_second", 99, 385, 3, 0);
    step(K_W, C_FREE);
    check("dj_second_rise.y", 32'(y_blue), 32'd377);
    step(K_0, C_FREE);
    check("dj_release2.y", 32'(y_blue), 32'd370);
    step(K_W, C_FREE);
    check("dj_third_ignored.y", 32'(y_blue), 32'd364);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
